clock_frequency_monitor: RTL and testbench

- Consumer-side checker for the clock/reset generation path; runs in the 100 MHz domain.
- Samples a slower generated clock (e.g. the 10 MHz output) as data and counts its rising edges over a fixed window of reference cycles.
- Reports the measured count, a lock indication after consecutive in-tolerance windows, and a sticky fault on out-of-tolerance or stalled clock.

---
 rtl/clock_frequency_monitor.sv | 189 ++++++++++++++++++
 tb/tb_clock_frequency_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_frequency_monitor.sv
// Clock frequency monitor: counts rising edges of a slower, asynchronous
// clock over fixed windows of reference cycles. Reports the count per window,
// a lock flag after consecutive in-tolerance windows, and a sticky fault on
// out-of-tolerance windows or a stalled monitored clock.
module clock_frequency_monitor #(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned MON_FREQUENCY = 10_000_000,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned TOLERANCE     = 2,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned STALL_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        en,
    input  logic        clk_mon,
    input  logic        fault_clr,
    output logic [15:0] freq_count,
    output logic        count_valid,
    output logic        locked,
    output logic        fault
);

    // 64-bit product avoids overflow of MON_FREQUENCY * WINDOW_CYCLES
    localparam logic [63:0] EXPECTED_64 =
        (64'(MON_FREQUENCY) * 64'(WINDOW_CYCLES)) / 64'(CLK_FREQUENCY);
    localparam logic [16:0] EXPECTED  = EXPECTED_64[16:0];
    localparam logic [16:0] TOL       = 17'(TOLERANCE);

    localparam int unsigned WIN_W   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int unsigned GOOD_W  = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_TRIG = STALL_W'(STALL_CYCLES - 1);
    localparam logic [GOOD_W-1:0]  GOOD_MAX   = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_settle_cnt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [15:0]        r_edge_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [GOOD_W-1:0]  r_good_cnt;
    logic [15:0]        r_freq_count;
    logic               r_count_valid;
    logic               r_locked;
    logic               r_fault;

    logic               w_edge;
    logic               w_measure;
    logic               w_win_last;
    logic               w_win_end;
    logic [15:0]        w_result;
    logic [16:0]        w_res_ext;
    logic [16:0]        w_diff;
    logic               w_good;
    logic               w_stall_hit;
    logic               w_fault_event;
    logic [GOOD_W-1:0]  w_good_inc;

    assign freq_count  = r_freq_count;
    assign count_valid = r_count_valid;
    assign locked      = r_locked;
    assign fault       = r_fault;

    // Next-state logic: settle for three cycles before measuring; en=0 always idles
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_SETTLE;
                ST_SETTLE:  if (r_settle_cnt == 2'd2) w_state_next = ST_MEASURE;
                ST_MEASURE: w_state_next = ST_MEASURE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Window evaluation, tolerance compare and fault event detection
    always_comb begin
        w_edge     = r_sync2 & ~r_sync3;
        w_measure  = (r_state == ST_MEASURE) && en;
        w_win_last = (r_win_cnt == WIN_LAST);
        w_win_end  = w_measure && w_win_last;
        w_result   = r_edge_cnt;
        if (w_edge && (r_edge_cnt != 16'hFFFF)) begin
            w_result = r_edge_cnt + 16'd1;
        end
        w_res_ext = {1'b0, w_result};
        if (w_res_ext >= EXPECTED) begin
            w_diff = w_res_ext - EXPECTED;
        end else begin
            w_diff = EXPECTED - w_res_ext;
        end
        w_good        = (w_diff <= TOL);
        w_stall_hit   = w_measure && !w_edge && (r_stall_cnt == STALL_TRIG);
        w_fault_event = (w_win_end && !w_good) || w_stall_hit;
        w_good_inc    = r_good_cnt;
        if (r_good_cnt != GOOD_MAX) begin
            w_good_inc = r_good_cnt + 1'b1;
        end
    end

    // State register and synchronizer chain
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= (r_state == ST_SETTLE && en) ? r_settle_cnt + 2'd1 : 2'd0;
            r_sync1      <= clk_mon;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
        end
    end

    // Window, edge, stall and good-window counters; result latch
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_win_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_good_cnt    <= '0;
            r_freq_count  <= '0;
            r_count_valid <= 1'b0;
        end else begin
            r_count_valid <= w_win_end;
            if (!w_measure) begin
                r_win_cnt   <= '0;
                r_edge_cnt  <= '0;
                r_stall_cnt <= '0;
                r_good_cnt  <= '0;
            end else begin
                r_win_cnt  <= w_win_last ? '0 : r_win_cnt + 1'b1;
                r_edge_cnt <= w_win_last ? '0 : w_result;
                if (w_edge) begin
                    r_stall_cnt <= '0;
                end else if (r_stall_cnt != STALL_MAX) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                if (w_win_end) begin
                    r_freq_count <= w_result;
                end
                if (w_fault_event) begin
                    r_good_cnt <= '0;
                end else if (w_win_end) begin
                    r_good_cnt <= w_good_inc;
                end
            end
        end
    end

    // Lock and sticky fault flags; a fault event always drops lock, set beats clear
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (!en || w_fault_event) begin
                r_locked <= 1'b0;
            end else if (w_win_end) begin
                r_locked <= (w_good_inc == GOOD_MAX);
            end
            if (w_fault_event) begin
                r_fault <= 1'b1;
            end else if (fault_clr) begin
                r_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_frequency_monitor.sv
// Directed bench for clock_frequency_monitor at default parameters.
module tb_clock_frequency_monitor;

    logic        clk = 1'b0;
    logic        rstb;
    logic        en;
    logic        clk_mon;
    logic        fault_clr;
    logic [15:0] freq_count;
    logic        count_valid;
    logic        locked;
    logic        fault;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int mon_period = 0;
    int phase      = 0;
    int last_rise  = 0;
    int n;
    int fault_cyc;
    int cv_seen;

    clock_frequency_monitor #(
        .CLK_FREQUENCY(100_000_000),
        .MON_FREQUENCY(10_000_000),
        .WINDOW_CYCLES(1000),
        .TOLERANCE(2),
        .LOCK_COUNT(3),
        .STALL_CYCLES(64)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .en(en),
        .clk_mon(clk_mon),
        .fault_clr(fault_clr),
        .freq_count(freq_count),
        .count_valid(count_valid),
        .locked(locked),
        .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitored clock: period in clk cycles (0 holds low), changes 2 ns after clk edges
    initial begin
        clk_mon = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mon_period == 0) begin
                clk_mon = 1'b0;
                phase   = 0;
            end else begin
                if (phase == 0) begin
                    clk_mon   = 1'b1;
                    last_rise = cyc;
                end else if (phase == mon_period / 2) begin
                    clk_mon = 1'b0;
                end
                phase = (phase + 1 >= mon_period) ? 0 : phase + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns the number of ticks until count_valid is seen, or -1 on timeout
    task automatic wait_cv(input int limit, output int ticks);
        bit done;
        ticks = -1;
        done  = 1'b0;
        for (int i = 1; i <= limit && !done; i++) begin
            tick();
            if (count_valid === 1'b1) begin
                ticks = i;
                done  = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] in_range(input logic [15:0] v, input int lo, input int hi);
        return ((int'(v) >= lo) && (int'(v) <= hi)) ? 32'd1 : 32'd0;
    endfunction

    initial begin
        rstb       = 1'b0;
        en         = 1'b0;
        fault_clr  = 1'b0;
        mon_period = 10;
        repeat (5) tick();
        check("rst_freq_count", 32'(freq_count), 0);
        check("rst_count_valid", 32'(count_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault), 0);

        // 10 MHz: first result 1004 cycles after enable, lock on third window
        rstb = 1'b1;
        en   = 1'b1;
        wait_cv(1100, n);
        check("first_cv_latency", n, 1004);
        check("w1_count_range", in_range(freq_count, 99, 101), 1);
        check("w1_locked", 32'(locked), 0);
        check("w1_fault", 32'(fault), 0);
        wait_cv(1100, n);
        check("cv_spacing", n, 1000);
        check("w2_count", 32'(freq_count), 100);
        check("w2_locked", 32'(locked), 0);
        wait_cv(1100, n);
        check("w3_locked", 32'(locked), 1);
        check("w3_fault", 32'(fault), 0);

        // Stall: fault 64 cycles after the last detected edge
        mon_period = 0;
        fault_cyc  = -1;
        for (int i = 0; i < 200 && fault_cyc < 0; i++) begin
            tick();
            if (fault === 1'b1) fault_cyc = cyc;
        end
        check("stall_fault_time", fault_cyc - last_rise, 67);
        check("stall_locked", 32'(locked), 0);
        wait_cv(1100, n);
        check("stall_window_low", in_range(freq_count, 0, 99), 1);
        check("stall_window_fault", 32'(fault), 1);

        // Restore, clear fault, relock after three good windows
        mon_period = 10;
        fault_clr  = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", 32'(fault), 0);
        wait_cv(1100, n);
        check("relock_spacing", n, 999);
        check("relock_w1_locked", 32'(locked), 0);
        wait_cv(1100, n);
        check("relock_w2_locked", 32'(locked), 0);
        wait_cv(1100, n);
        check("relock_w3_locked", 32'(locked), 1);
        check("relock_w3_count", 32'(freq_count), 100);
        check("relock_w3_fault", 32'(fault), 0);

        // Drop enable mid-window
        repeat (500) tick();
        en = 1'b0;
        tick();
        check("dis_locked", 32'(locked), 0);
        cv_seen = (count_valid === 1'b1) ? 1 : 0;
        repeat (1100) begin
            tick();
            if (count_valid === 1'b1) cv_seen++;
        end
        check("dis_no_cv", cv_seen, 0);
        check("dis_freq_count", 32'(freq_count), 100);
        check("dis_fault", 32'(fault), 0);
        en = 1'b1;
        wait_cv(1100, n);
        check("reen_latency", n, 1004);
        check("reen_count_range", in_range(freq_count, 99, 101), 1);
        wait_cv(1100, n);
        wait_cv(1100, n);
        check("reen_locked", 32'(locked), 1);

        // 8.33 MHz: bad window; fault_clr in the same cycle loses to the set
        mon_period = 12;
        repeat (999) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("slow_cv", 32'(count_valid), 1);
        check("slow_count_range", in_range(freq_count, 82, 84), 1);
        check("slow_fault_set_wins", 32'(fault), 1);
        check("slow_locked", 32'(locked), 0);
        mon_period = 10;
        tick();
        check("slow_fault_sticky", 32'(fault), 1);
        wait_cv(1100, n);
        wait_cv(1100, n);
        check("fl_w2_locked", 32'(locked), 0);
        wait_cv(1100, n);
        check("fl_w3_locked", 32'(locked), 1);
        check("fl_w3_fault", 32'(fault), 1);

        // Reset mid-window while locked with fault set
        repeat (300) tick();
        rstb = 1'b0;
        tick();
        check("mrst_freq_count", 32'(freq_count), 0);
        check("mrst_count_valid", 32'(count_valid), 0);
        check("mrst_locked", 32'(locked), 0);
        check("mrst_fault", 32'(fault), 0);
        rstb = 1'b1;
        wait_cv(1100, n);
        check("mrst_next_cv", n, 1004);
        check("mrst_cv_locked", 32'(locked), 0);
        check("mrst_cv_fault", 32'(fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
